// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 execute stage: opcode nibbles, ALU sub-ops,
// trap codes and the execute FSM state encoding.
package chip8_pkg;

  localparam logic [11:0] PC_RESET_DEF = 12'h200;

  localparam logic [3:0] OP_SYS    = 4'h0;
  localparam logic [3:0] OP_JP     = 4'h1;
  localparam logic [3:0] OP_CALL   = 4'h2;
  localparam logic [3:0] OP_SE_I   = 4'h3;
  localparam logic [3:0] OP_SNE_I  = 4'h4;
  localparam logic [3:0] OP_SE_R   = 4'h5;
  localparam logic [3:0] OP_LD_I   = 4'h6;
  localparam logic [3:0] OP_ADD_I  = 4'h7;
  localparam logic [3:0] OP_ALU    = 4'h8;
  localparam logic [3:0] OP_SNE_R  = 4'h9;
  localparam logic [3:0] OP_LD_IDX = 4'hA;
  localparam logic [3:0] OP_JP_V0  = 4'hB;
  localparam logic [3:0] OP_RND    = 4'hC;
  localparam logic [3:0] OP_MISC   = 4'hF;

  localparam logic [7:0] FX_GET_DT = 8'h07;
  localparam logic [7:0] FX_SET_DT = 8'h15;
  localparam logic [7:0] FX_SET_ST = 8'h18;
  localparam logic [7:0] FX_ADD_I  = 8'h1E;

  // 8XYN sub-ops keep their N encoding; 7XNN borrows an unused code
  typedef enum logic [3:0] {
    ALU_MOV  = 4'h0,
    ALU_OR   = 4'h1,
    ALU_AND  = 4'h2,
    ALU_XOR  = 4'h3,
    ALU_ADD  = 4'h4,
    ALU_SUB  = 4'h5,
    ALU_SHR  = 4'h6,
    ALU_SUBN = 4'h7,
    ALU_ADDI = 4'h8,
    ALU_SHL  = 4'hE
  } alu_op_e;

  typedef enum logic [1:0] {
    TRAP_NONE      = 2'b00,
    TRAP_UNSUP     = 2'b01,
    TRAP_OVERFLOW  = 2'b10,
    TRAP_UNDERFLOW = 2'b11
  } trap_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE,
    ST_HALT
  } state_e;

  function automatic logic is_alu_subop(input logic [3:0] n);
    return (n <= 4'h7) || (n == 4'hE);
  endfunction

endpackage

// File: rtl/chip8_alu.sv
// Combinational datapath for 8XYN and 7XNN: result for VX plus optional VF flag.
module chip8_alu
  import chip8_pkg::*;
(
  input  logic [7:0] vx,
  input  logic [7:0] vy,
  input  logic [7:0] nn,
  input  alu_op_e    op,
  output logic [7:0] result,
  output logic       flag,
  output logic       flag_we
);

  logic [8:0] sum;
  assign sum = {1'b0, vx} + {1'b0, vy};

  always_comb begin
    result  = vx;
    flag    = 1'b0;
    flag_we = 1'b0;
    case (op)
      ALU_MOV:  result = vy;
      ALU_OR:   result = vx | vy;
      ALU_AND:  result = vx & vy;
      ALU_XOR:  result = vx ^ vy;
      ALU_ADD: begin
        result  = sum[7:0];
        flag    = sum[8];
        flag_we = 1'b1;
      end
      ALU_SUB: begin
        result  = vx - vy;
        flag    = (vx >= vy);
        flag_we = 1'b1;
      end
      ALU_SHR: begin
        result  = {1'b0, vx[7:1]};
        flag    = vx[0];
        flag_we = 1'b1;
      end
      ALU_SUBN: begin
        result  = vy - vx;
        flag    = (vy >= vx);
        flag_we = 1'b1;
      end
      ALU_SHL: begin
        result  = {vx[6:0], 1'b0};
        flag    = vx[7];
        flag_we = 1'b1;
      end
      ALU_ADDI: result = vx + nn;
      default:  result = vx;
    endcase
  end

endmodule

// File: rtl/chip8_exec.sv
// CHIP-8 execute stage: owns V0-VF, I, PC, call stack, timers and LFSR; commits one
// decoded instruction per IDLE->EXEC->DONE pass and halts on unsupported/stack traps.
module chip8_exec
  import chip8_pkg::*;
#(
  parameter logic [11:0] PC_RESET    = PC_RESET_DEF,
  parameter int          STACK_DEPTH = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [3:0]  instr,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [3:0]  n,
  input  logic [7:0]  nn,
  input  logic [11:0] nnn,
  input  logic        tick_60hz,
  output logic        done,
  output logic [11:0] pc,
  output logic [11:0] i_reg,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        sound_on,
  output logic        trap,
  output logic [1:0]  trap_code
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam int AW   = SP_W - 1;

  state_e      state_reg;
  logic        dec_ready_reg, done_reg, trap_reg;
  trap_code_e  trap_code_reg;
  logic [3:0]  instr_reg, x_reg, y_reg, n_reg;
  logic [7:0]  nn_reg;
  logic [11:0] nnn_reg;
  logic [11:0] pc_reg, idx_reg;
  logic [SP_W-1:0] sp_reg;
  logic [11:0] stack_mem [STACK_DEPTH];
  logic [7:0]  v_reg [16];
  logic [7:0]  delay_reg, sound_reg;
  logic [15:0] lfsr_reg;

  logic [7:0]  vx, vy;
  logic [11:0] pc_plus2, pc_plus4, stack_top;
  logic [AW-1:0] pop_idx;
  alu_op_e     alu_op;
  logic [7:0]  alu_result;
  logic        alu_flag, alu_flag_we;

  logic [11:0] pc_next, i_next;
  logic [7:0]  v_wdata, vf_data;
  logic        v_we, vf_we, i_we, push, pop, dt_we, st_we, trap_hit;
  trap_code_e  trap_kind;
  logic        commit;

  assign vx        = v_reg[x_reg];
  assign vy        = v_reg[y_reg];
  assign pc_plus2  = pc_reg + 12'd2;
  assign pc_plus4  = pc_reg + 12'd4;
  assign pop_idx   = sp_reg[AW-1:0] - AW'(1);
  assign stack_top = stack_mem[pop_idx];
  assign alu_op    = (instr_reg == OP_ADD_I) ? ALU_ADDI : alu_op_e'(n_reg);

  chip8_alu u_alu (
    .vx      (vx),
    .vy      (vy),
    .nn      (nn_reg),
    .op      (alu_op),
    .result  (alu_result),
    .flag    (alu_flag),
    .flag_we (alu_flag_we)
  );

  always_comb begin
    pc_next   = pc_plus2;
    i_next    = idx_reg;
    v_wdata   = nn_reg;
    vf_data   = 8'h00;
    v_we      = 1'b0;
    vf_we     = 1'b0;
    i_we      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    dt_we     = 1'b0;
    st_we     = 1'b0;
    trap_hit  = 1'b0;
    trap_kind = TRAP_UNSUP;
    case (instr_reg)
      OP_SYS: begin
        if (nnn_reg != 12'h0EE) begin
          trap_hit = 1'b1;
        end else if (sp_reg == '0) begin
          trap_hit  = 1'b1;
          trap_kind = TRAP_UNDERFLOW;
        end else begin
          pop     = 1'b1;
          pc_next = stack_top;
        end
      end
      OP_JP: pc_next = nnn_reg;
      OP_CALL: begin
        if (sp_reg == SP_W'(STACK_DEPTH)) begin
          trap_hit  = 1'b1;
          trap_kind = TRAP_OVERFLOW;
        end else begin
          push    = 1'b1;
          pc_next = nnn_reg;
        end
      end
      OP_SE_I:  if (vx == nn_reg) pc_next = pc_plus4;
      OP_SNE_I: if (vx != nn_reg) pc_next = pc_plus4;
      OP_SE_R: begin
        if (n_reg != 4'h0) trap_hit = 1'b1;
        else if (vx == vy) pc_next = pc_plus4;
      end
      OP_LD_I: v_we = 1'b1;
      OP_ADD_I: begin
        v_we    = 1'b1;
        v_wdata = alu_result;
      end
      OP_ALU: begin
        if (is_alu_subop(n_reg)) begin
          v_we    = 1'b1;
          v_wdata = alu_result;
          vf_we   = alu_flag_we;
          vf_data = {7'd0, alu_flag};
        end else begin
          trap_hit = 1'b1;
        end
      end
      OP_SNE_R: begin
        if (n_reg != 4'h0) trap_hit = 1'b1;
        else if (vx != vy) pc_next = pc_plus4;
      end
      OP_LD_IDX: begin
        i_we   = 1'b1;
        i_next = nnn_reg;
      end
      OP_JP_V0: pc_next = nnn_reg + {4'd0, v_reg[0]};
      OP_RND: begin
        v_we    = 1'b1;
        v_wdata = lfsr_reg[7:0] & nn_reg;
      end
      OP_MISC: begin
        case (nn_reg)
          FX_GET_DT: begin
            v_we    = 1'b1;
            v_wdata = delay_reg;
          end
          FX_SET_DT: dt_we = 1'b1;
          FX_SET_ST: st_we = 1'b1;
          FX_ADD_I: begin
            i_we   = 1'b1;
            i_next = idx_reg + {4'd0, vx};
          end
          default: trap_hit = 1'b1;
        endcase
      end
      default: trap_hit = 1'b1;
    endcase
  end

  assign commit = (state_reg == ST_EXEC) && !trap_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      dec_ready_reg <= 1'b1;
      done_reg      <= 1'b0;
      trap_reg      <= 1'b0;
      trap_code_reg <= TRAP_NONE;
      pc_reg        <= PC_RESET;
      idx_reg       <= 12'd0;
      sp_reg        <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dec_valid) begin
            state_reg     <= ST_EXEC;
            dec_ready_reg <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (trap_hit) begin
            state_reg     <= ST_HALT;
            trap_reg      <= 1'b1;
            trap_code_reg <= trap_kind;
          end else begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            pc_reg    <= pc_next;
            if (i_we) idx_reg <= i_next;
            if (push) sp_reg <= sp_reg + SP_W'(1);
            else if (pop) sp_reg <= sp_reg - SP_W'(1);
          end
        end
        ST_DONE: begin
          state_reg     <= ST_IDLE;
          done_reg      <= 1'b0;
          dec_ready_reg <= 1'b1;
        end
        default: state_reg <= ST_HALT;
      endcase
    end
  end

  // Fields are only captured on an actual handshake in IDLE
  always_ff @(posedge clk) begin
    if (state_reg == ST_IDLE && dec_valid) begin
      instr_reg <= instr;
      x_reg     <= x;
      y_reg     <= y;
      n_reg     <= n;
      nn_reg    <= nn;
      nnn_reg   <= nnn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && push) stack_mem[sp_reg[AW-1:0]] <= pc_plus2;
  end

  // VF write is checked first so a flag always overrides a result aimed at VF
  for (genvar gi = 0; gi < 16; gi++) begin : g_vreg
    always_ff @(posedge clk) begin
      if (reset) begin
        v_reg[gi] <= 8'h00;
      end else if (commit) begin
        if (vf_we && gi == 15) v_reg[gi] <= vf_data;
        else if (v_we && x_reg == 4'(gi)) v_reg[gi] <= v_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delay_reg <= 8'h00;
      sound_reg <= 8'h00;
      lfsr_reg  <= LFSR_SEED;
    end else begin
      if (commit && dt_we) delay_reg <= vx;
      else if (tick_60hz && delay_reg != 8'h00) delay_reg <= delay_reg - 8'd1;
      if (commit && st_we) sound_reg <= vx;
      else if (tick_60hz && sound_reg != 8'h00) sound_reg <= sound_reg - 8'd1;
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  assign dec_ready = dec_ready_reg;
  assign done      = done_reg;
  assign pc        = pc_reg;
  assign i_reg     = idx_reg;
  assign rd_data   = v_reg[rd_addr];
  assign sound_on  = (sound_reg != 8'h00);
  assign trap      = trap_reg;
  assign trap_code = trap_code_reg;

endmodule

// File: tb/tb_chip8_exec.sv
// Directed bench for chip8_exec: vector table for single instructions, then hand
// sequences for timers, traps, stack limits and reset mid-instruction.
module tb_chip8_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  instr, x, y, n;
  logic [7:0]  nn;
  logic [11:0] nnn;
  logic        tick_60hz;
  logic        done;
  logic [11:0] pc, i_reg;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        sound_on, trap;
  logic [1:0]  trap_code;

  int n_checks = 0;
  int n_fail   = 0;

  chip8_exec dut (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .instr     (instr),
    .x         (x),
    .y         (y),
    .n         (n),
    .nn        (nn),
    .nnn       (nnn),
    .tick_60hz (tick_60hz),
    .done      (done),
    .pc        (pc),
    .i_reg     (i_reg),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sound_on  (sound_on),
    .trap      (trap),
    .trap_code (trap_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] op;
    logic [3:0]  ra;
    logic [7:0]  rv;
    bit          vf_en;
    logic [7:0]  vf;
    logic [11:0] pc;
    logic [11:0] ir;
  } vec_t;

  vec_t vecs [34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic read_v(input logic [3:0] a, output logic [7:0] val);
    rd_addr = a;
    #1;
    val = rd_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dec_valid = 1'b0;
    tick_60hz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input logic [15:0] op);
    instr = op[15:12];
    x     = op[11:8];
    y     = op[7:4];
    n     = op[3:0];
    nn    = op[7:0];
    nnn   = op[11:0];
  endtask

  task automatic pulse_ticks(input int k);
    for (int t = 0; t < k; t++) begin
      @(negedge clk);
      tick_60hz = 1'b1;
      @(negedge clk);
      tick_60hz = 1'b0;
    end
  endtask

  // Handshake one instruction; tick_exec raises tick_60hz only for the commit edge.
  task automatic issue(input logic [15:0] op, input bit tick_exec,
                       output bit got_done, output bit got_trap);
    int waited;
    got_done = 1'b0;
    got_trap = 1'b0;
    @(negedge clk);
    drive(op);
    dec_valid = 1'b1;
    waited = 0;
    while (!dec_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!dec_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: op %h never accepted, dec_ready=%0b", op, dec_ready);
      dec_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
    tick_60hz = tick_exec;
    @(negedge clk);
    check("done_early", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    tick_60hz = 1'b0;
    @(negedge clk);
    got_done = done;
    got_trap = trap;
    if (got_done) begin
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("ready_back", {31'd0, dec_ready}, 32'd1);
    end
    $display("op %h: done=%0b trap=%0b pc=%h i=%h", op, got_done, got_trap, pc, i_reg);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gd, gt;
    logic [7:0] val;
    int seen;

    vecs[0]  = '{16'h6A05, 4'hA, 8'h05, 1'b0, 8'h00, 12'h202, 12'h000};
    vecs[1]  = '{16'h6B0A, 4'hB, 8'h0A, 1'b0, 8'h00, 12'h204, 12'h000};
    vecs[2]  = '{16'h8AB4, 4'hA, 8'h0F, 1'b1, 8'h00, 12'h206, 12'h000};
    vecs[3]  = '{16'h6AFF, 4'hA, 8'hFF, 1'b0, 8'h00, 12'h208, 12'h000};
    vecs[4]  = '{16'h6B02, 4'hB, 8'h02, 1'b0, 8'h00, 12'h20A, 12'h000};
    vecs[5]  = '{16'h8AB4, 4'hA, 8'h01, 1'b1, 8'h01, 12'h20C, 12'h000};
    vecs[6]  = '{16'h6F03, 4'hF, 8'h03, 1'b0, 8'h00, 12'h20E, 12'h000};
    vecs[7]  = '{16'h6A01, 4'hA, 8'h01, 1'b0, 8'h00, 12'h210, 12'h000};
    vecs[8]  = '{16'h8FA5, 4'hF, 8'h01, 1'b0, 8'h00, 12'h212, 12'h000};
    vecs[9]  = '{16'h6C11, 4'hC, 8'h11, 1'b0, 8'h00, 12'h214, 12'h000};
    vecs[10] = '{16'h3C11, 4'hC, 8'h11, 1'b0, 8'h00, 12'h218, 12'h000};
    vecs[11] = '{16'h4C11, 4'hC, 8'h11, 1'b0, 8'h00, 12'h21A, 12'h000};
    vecs[12] = '{16'h7CF0, 4'hC, 8'h01, 1'b1, 8'h01, 12'h21C, 12'h000};
    vecs[13] = '{16'h8C06, 4'hC, 8'h00, 1'b1, 8'h01, 12'h21E, 12'h000};
    vecs[14] = '{16'h6D81, 4'hD, 8'h81, 1'b0, 8'h00, 12'h220, 12'h000};
    vecs[15] = '{16'h8D0E, 4'hD, 8'h02, 1'b1, 8'h01, 12'h222, 12'h000};
    vecs[16] = '{16'h6E0F, 4'hE, 8'h0F, 1'b0, 8'h00, 12'h224, 12'h000};
    vecs[17] = '{16'h8DE1, 4'hD, 8'h0F, 1'b1, 8'h01, 12'h226, 12'h000};
    vecs[18] = '{16'h8DE3, 4'hD, 8'h00, 1'b1, 8'h01, 12'h228, 12'h000};
    vecs[19] = '{16'h6203, 4'h2, 8'h03, 1'b0, 8'h00, 12'h22A, 12'h000};
    vecs[20] = '{16'h8257, 4'h2, 8'hFD, 1'b1, 8'h00, 12'h22C, 12'h000};
    vecs[21] = '{16'hA123, 4'h2, 8'hFD, 1'b0, 8'h00, 12'h22E, 12'h123};
    vecs[22] = '{16'hF21E, 4'h2, 8'hFD, 1'b1, 8'h00, 12'h230, 12'h220};
    vecs[23] = '{16'h6005, 4'h0, 8'h05, 1'b0, 8'h00, 12'h232, 12'h220};
    vecs[24] = '{16'hB300, 4'h0, 8'h05, 1'b0, 8'h00, 12'h305, 12'h220};
    vecs[25] = '{16'h1400, 4'h0, 8'h05, 1'b0, 8'h00, 12'h400, 12'h220};
    vecs[26] = '{16'h5220, 4'h2, 8'hFD, 1'b0, 8'h00, 12'h404, 12'h220};
    vecs[27] = '{16'h9230, 4'h3, 8'h00, 1'b0, 8'h00, 12'h408, 12'h220};
    vecs[28] = '{16'h6755, 4'h7, 8'h55, 1'b0, 8'h00, 12'h40A, 12'h220};
    vecs[29] = '{16'hC700, 4'h7, 8'h00, 1'b0, 8'h00, 12'h40C, 12'h220};
    vecs[30] = '{16'h2500, 4'h7, 8'h00, 1'b0, 8'h00, 12'h500, 12'h220};
    vecs[31] = '{16'h00EE, 4'h7, 8'h00, 1'b0, 8'h00, 12'h40E, 12'h220};
    vecs[32] = '{16'h8AB2, 4'hA, 8'h00, 1'b1, 8'h00, 12'h410, 12'h220};
    vecs[33] = '{16'h8AB0, 4'hA, 8'h02, 1'b0, 8'h00, 12'h412, 12'h220};

    reset = 1'b1; dec_valid = 1'b0; tick_60hz = 1'b0; rd_addr = 4'h0;
    drive(16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_pc", {20'd0, pc}, 32'h200);
    check("rst_i", {20'd0, i_reg}, 32'h0);
    check("rst_ready", {31'd0, dec_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_trap", {29'd0, trap, trap_code}, 32'd0);
    check("rst_sound", {31'd0, sound_on}, 32'd0);
    read_v(4'hF, val);
    check("rst_vf", {24'd0, val}, 32'd0);

    for (int k = 0; k < 34; k++) begin
      issue(vecs[k].op, 1'b0, gd, gt);
      check($sformatf("v%0d_done", k), {31'd0, gd}, 32'd1);
      check($sformatf("v%0d_pc", k), {20'd0, pc}, {20'd0, vecs[k].pc});
      check($sformatf("v%0d_i", k), {20'd0, i_reg}, {20'd0, vecs[k].ir});
      read_v(vecs[k].ra, val);
      check($sformatf("v%0d_V%0h", k, vecs[k].ra), {24'd0, val}, {24'd0, vecs[k].rv});
      if (vecs[k].vf_en) begin
        read_v(4'hF, val);
        check($sformatf("v%0d_VF", k), {24'd0, val}, {24'd0, vecs[k].vf});
      end
    end

    // Delay timer: load, four ticks, read back
    issue(16'h6A3C, 1'b0, gd, gt);
    issue(16'hFA15, 1'b0, gd, gt);
    pulse_ticks(4);
    issue(16'hFB07, 1'b0, gd, gt);
    read_v(4'hB, val);
    check("dt_after_4_ticks", {24'd0, val}, 32'h38);
    // Load coincident with a tick: the written value wins
    issue(16'h6A20, 1'b0, gd, gt);
    issue(16'hFA15, 1'b1, gd, gt);
    issue(16'hFB07, 1'b0, gd, gt);
    read_v(4'hB, val);
    check("dt_write_beats_tick", {24'd0, val}, 32'h20);
    issue(16'hFA18, 1'b0, gd, gt);
    check("sound_on_loaded", {31'd0, sound_on}, 32'd1);
    check("pc_before_trap", {20'd0, pc}, 32'h420);
    pulse_ticks(31);
    check("sound_on_31_ticks", {31'd0, sound_on}, 32'd1);
    pulse_ticks(1);
    check("sound_off_32_ticks", {31'd0, sound_on}, 32'd0);

    // Unsupported opcode halts without a done pulse
    issue(16'hD125, 1'b0, gd, gt);
    check("d125_done", {31'd0, gd}, 32'd0);
    check("d125_trap", {31'd0, trap}, 32'd1);
    check("d125_code", {30'd0, trap_code}, 32'd1);
    check("d125_pc", {20'd0, pc}, 32'h420);
    check("d125_ready", {31'd0, dec_ready}, 32'd0);
    seen = 0;
    drive(16'h6A77);
    dec_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen += int'(done) + int'(dec_ready);
    end
    dec_valid = 1'b0;
    check("halt_quiet", seen, 0);
    read_v(4'hA, val);
    check("halt_ignores_valid", {24'd0, val}, 32'h20);
    check("halt_pc_frozen", {20'd0, pc}, 32'h420);
    check("halt_code_sticky", {29'd0, trap, trap_code}, 32'h5);

    // Stack fills at 16 entries; the 17th call traps
    do_reset();
    check("trap_cleared", {29'd0, trap, trap_code}, 32'd0);
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      issue(16'h2300, 1'b0, gd, gt);
      seen += int'(gd);
    end
    check("calls_done", seen, 16);
    check("calls_pc", {20'd0, pc}, 32'h300);
    issue(16'h2300, 1'b0, gd, gt);
    check("ovf_done", {31'd0, gd}, 32'd0);
    check("ovf_trap", {29'd0, trap, trap_code}, 32'h6);
    check("ovf_pc", {20'd0, pc}, 32'h300);
    check("ovf_ready", {31'd0, dec_ready}, 32'd0);

    do_reset();
    issue(16'h00EE, 1'b0, gd, gt);
    check("udf_trap", {29'd0, trap, trap_code}, 32'h7);
    check("udf_pc", {20'd0, pc}, 32'h200);

    // Reset while the instruction sits in EXEC discards it
    do_reset();
    @(negedge clk);
    drive(16'h1555);
    dec_valid = 1'b1;
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'd0, dec_ready}, 32'd1);
    check("midrst_pc", {20'd0, pc}, 32'h200);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen += int'(done);
    end
    check("midrst_no_done", seen, 0);
    check("midrst_pc_hold", {20'd0, pc}, 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
